// File: rtl/reg_file_32x32_if.sv
// -----------------------------------------------------------------------------
// reg_file_32x32_if
//
// Bundles the register-file read/write bus for the KGP-RISC datapath.
//
//   rs_addr / rt_addr : operand read addresses (driven by the decode stage)
//   rs_data / rt_data : operand read data (combinational, driven by the file)
//   wr_addr           : destination register select (write-address mux output)
//   wr_data           : write-back data
//   wr_en             : write strobe, sampled on the rising clock edge
//
// Modports:
//   master : the datapath side that issues addresses and write-back data
//   slave  : the register file itself
// -----------------------------------------------------------------------------
interface reg_file_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  modport master (
    output rs_addr,
    output rt_addr,
    output wr_addr,
    output wr_data,
    output wr_en,
    input  rs_data,
    input  rt_data
  );

  modport slave (
    input  rs_addr,
    input  rt_addr,
    input  wr_addr,
    input  wr_data,
    input  wr_en,
    output rs_data,
    output rt_data
  );

endinterface

// File: rtl/reg_file_32x32.sv
// -----------------------------------------------------------------------------
// reg_file_32x32
//
// Architectural register file for KGP-RISC: 2**ADDR_W entries of DATA_W bits
// held in flip-flops, one write port and two combinational read ports.
// Register 0 is hardwired to zero. With BYPASS=1 a read of the register being
// written in the current cycle returns the incoming write-back data, hiding
// the write-back/decode hazard.
//
// Ports:
//   clk  : system clock, rising-edge active
//   rst  : synchronous active-high reset, clears every entry
//   bus  : reg_file_32x32_if.slave
//            rs_addr, rt_addr -> rs_data, rt_data (combinational reads)
//            wr_addr, wr_data, wr_en           (edge-committed write)
//
// Parameters:
//   DATA_W : register width
//   ADDR_W : address width, depth = 2**ADDR_W
//   BYPASS : 1 = same-cycle write-to-read forwarding, 0 = stored value only
// -----------------------------------------------------------------------------
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_file_32x32_if.slave        bus
);

  localparam int  DEPTH     = 1 << ADDR_W;
  localparam logic BYPASS_EN = (BYPASS != 0);

  // Storage: a plain flop array, no memory macro.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic             wr_commit;
  logic [DEPTH-1:0] wr_sel;
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  // One-hot decode of a register address.
  function automatic logic [DEPTH-1:0] decode_onehot(input logic [ADDR_W-1:0] addr);
    logic [DEPTH-1:0] sel;
    sel       = '0;
    sel[addr] = 1'b1;
    return sel;
  endfunction

  // Read-port select: r0 is always zero; a bypass hit forwards the
  // write-back data; otherwise the pre-edge stored value is returned.
  function automatic logic [DATA_W-1:0] read_select(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              commit,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] value;
    if (addr == '0) begin
      value = '0;
    end else if (BYPASS_EN && commit && (addr == waddr)) begin
      value = wdata;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  // A write only takes effect when it is strobed, not overridden by reset,
  // and not aimed at r0. The same qualifier gates the bypass, so a reset
  // cycle or an r0 write can never leak wr_data onto the read ports.
  assign wr_commit = bus.wr_en && !rst && (bus.wr_addr != '0);

  always_comb begin
    wr_sel    = decode_onehot(bus.wr_addr) & {DEPTH{wr_commit}};
    // Bit 0 is masked explicitly so r0 stays zero even if the qualifier
    // above were ever relaxed.
    wr_sel[0] = 1'b0;
  end

  // Next-state of the array: hold, or take wr_data on the selected entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = bus.wr_data;
      end
    end
    regs_d[0] = '0;
  end

  // Write commit at the clock edge; reset wins over any write in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    rs_stored = regs_q[bus.rs_addr];
    rt_stored = regs_q[bus.rt_addr];
  end

  assign bus.rs_data = read_select(bus.rs_addr, rs_stored, wr_commit,
                                   bus.wr_addr, bus.wr_data);
  assign bus.rt_data = read_select(bus.rt_addr, rt_stored, wr_commit,
                                   bus.wr_addr, bus.wr_data);

endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Architectural register file for KGP-RISC. It is the receiving end of the 5-bit destination-register select path: the write-address mux output lands here. The block decodes the address and commits write-back data on the clock edge. It also serves two combinational read ports for the rs/rt operands. Register 0 is hardwired to zero, and an optional same-cycle write-to-read bypass removes the write-back/decode hazard.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data; 0 = returns the stored value

- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- wr_addr  input  ADDR_W  write address (from the 5-bit destination mux)
- wr_data  input  DATA_W  write-back data
- wr_en  input  1  write strobe, sampled on the rising edge of clk
- rs_data  output  DATA_W  read port A data, combinational
- rt_data  output  DATA_W  read port B data, combinational

## Operation
- Storage: 32 x DATA_W flip-flop array. No memory macro.
- Write decode: one-hot decode of wr_addr, gated by wr_en.
- A write commits at the rising edge when wr_en=1, rst=0 and wr_addr != 0.
- Writes to address 0 are discarded. Entry 0 always holds 0.
- Reset: at a rising edge with rst=1, all 32 entries clear to 0.
  - rst has priority over wr_en; a write in a reset cycle is lost.
- Reset mid-operation: any pending write in that cycle is dropped. No partial state survives.
- Reads: rs_data and rt_data are purely combinational from rs_addr and rt_addr.
  - Address 0 always reads 0.
  - rs_addr == rt_addr is legal; both ports return the same value.
- Bypass, with BYPASS=1: if wr_en=1, rst=0, wr_addr != 0 and the read address equals wr_addr, the port returns wr_data in the same cycle.
  - This applies to each port independently, so both may bypass at once.
- Bypass is suppressed when rst=1, so the port returns the stored value.
- Bypass is suppressed for address 0, which still reads 0.
- With BYPASS=0 a read always shows the pre-edge stored value.
- No X propagation: every output is defined for every input combination after the first reset edge.

## Timing
- Write latency: data is visible via the array one edge after wr_en is sampled. Without bypass it shows on the read ports in the following cycle.
- Bypass latency: 0 cycles (combinational path wr_data -> rs_data/rt_data).
- Read latency: 0 cycles (combinational path from address to data).
- Output reset values: all entries read 0 after the first rst edge.
  - rs_data = rt_data = 0 for any address from that edge until the first committed write.
- Before the first reset edge, contents are undefined. The bench must not check outputs before reset.
- Back-to-back writes to the same address: the last write wins. Each edge commits exactly one write.
- Write and read of the same register in the same cycle: the result is governed by BYPASS as above. The array updates at the edge either way.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, then hold rst=1 for one edge -> rs_addr=5 reads 0x00000000; all 32 addresses read 0.
- Write/read both ports: write 0x12345678 to r31 and 0x0000FFFF to r1 on consecutive edges. Then set rs_addr=31, rt_addr=1 -> rs_data=0x12345678, rt_data=0x0000FFFF.
- r0 hardwired: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF -> rs_addr=0 and rt_addr=0 read 0, both in the same cycle and after the edge.
- Bypass: r7 holds 0x11111111. In one cycle drive wr_addr=7, wr_data=0x22222222, wr_en=1, rs_addr=rt_addr=7.
  - BYPASS=1 -> both ports read 0x22222222 before the edge.
  - BYPASS=0 -> both ports read 0x11111111 before the edge and 0x22222222 after it.
- Reset vs write collision: rst=1, wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5 at the same edge -> r9 reads 0. During that cycle rs_addr=9 shows the stored value, not 0xA5A5A5A5.
- Sweep: write value (addr*0x01010101) to addresses 1..31 on successive edges, then read back all 32 on both ports -> each matches, and addr 0 reads 0.
